// File: rtl/seg_scan_display_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: segment patterns,
// idle pin levels and default scan timing.
package seg_scan_display_pkg;

  localparam int SCAN_DIV_DEFAULT   = 100000;
  localparam int GAP_CYCLES_DEFAULT = 1000;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {dp,g,f,e,d,c,b,a}; dp bit left set so the pattern alone is dp-off.
  localparam logic [7:0] SEG_PATTERN [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern {g,f,e,d,c,b,a}.
module seg_hex_decode
  import seg_scan_display_pkg::*;
(
  input  logic [3:0] hexIn,
  output logic [6:0] segOut
);

  always_comb begin
    segOut = SEG_PATTERN[hexIn][6:0];
  end

endmodule

// File: rtl/seg_scan_display.sv
// Four-digit multiplexed 7-segment scanner with per-slot blanking gap and
// frame-synchronous (tear-free) update of the displayed value.
module seg_scan_display
  import seg_scan_display_pkg::*;
#(
  parameter int SCAN_DIV   = SCAN_DIV_DEFAULT,
  parameter int GAP_CYCLES = GAP_CYCLES_DEFAULT
)
(
  input  logic        CLK,
  input  logic        Reset,
  input  logic [15:0] DataIn,
  input  logic [3:0]  DpIn,
  input  logic [3:0]  BlankIn,
  input  logic        Load,
  output logic [3:0]  AN,
  output logic [7:0]  SEG,
  output logic        FrameTick
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_GAP  = CNT_W'(GAP_CYCLES);

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;

  logic [15:0] pendData, actData;
  logic [3:0]  pendDp, actDp;
  logic [3:0]  pendBlank, actBlank;

  logic        slotEnd;
  logic        frameEnd;
  logic        inGap;
  logic [3:0]  nibble;
  logic [6:0]  segDec;
  logic [3:0]  anNext;
  logic [7:0]  segNext;

  seg_hex_decode uDecode (
    .hexIn  (nibble),
    .segOut (segDec)
  );

  always_comb begin
    slotEnd  = (cnt == CNT_LAST);
    frameEnd = slotEnd && (idx == 2'd3);
    inGap    = (cnt < CNT_GAP);
    nibble   = actData[{idx, 2'b00} +: 4];

    anNext  = AN_OFF;
    segNext = SEG_OFF;
    // A blanked digit keeps its anode off and its cathodes dark for the whole slot.
    if (!inGap && !actBlank[idx]) begin
      anNext  = ~(4'b0001 << idx);
      segNext = {~actDp[idx], segDec};
    end
  end

  // Stage boundary: (cnt, idx, active) -> registered pins, one cycle later.
  always_ff @(posedge CLK) begin
    if (!Reset) begin
      cnt       <= '0;
      idx       <= 2'd0;
      pendData  <= 16'h0000;
      pendDp    <= 4'h0;
      pendBlank <= 4'hF;
      actData   <= 16'h0000;
      actDp     <= 4'h0;
      actBlank  <= 4'hF;
      AN        <= AN_OFF;
      SEG       <= SEG_OFF;
      FrameTick <= 1'b0;
    end else begin
      cnt <= slotEnd ? '0 : cnt + CNT_W'(1);
      if (slotEnd) idx <= idx + 2'd1;

      if (Load) begin
        pendData  <= DataIn;
        pendDp    <= DpIn;
        pendBlank <= BlankIn;
      end

      // A Load landing on the boundary itself goes straight to the display.
      if (frameEnd) begin
        if (Load) begin
          actData  <= DataIn;
          actDp    <= DpIn;
          actBlank <= BlankIn;
        end else begin
          actData  <= pendData;
          actDp    <= pendDp;
          actBlank <= pendBlank;
        end
      end

      AN        <= anNext;
      SEG       <= segNext;
      FrameTick <= frameEnd;
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display at SCAN_DIV=8, GAP_CYCLES=2.
module tb_seg_scan_display;

  logic        CLK = 1'b0;
  logic        Reset;
  logic [15:0] DataIn;
  logic [3:0]  DpIn;
  logic [3:0]  BlankIn;
  logic        Load;
  logic [3:0]  AN;
  logic [7:0]  SEG;
  logic        FrameTick;

  seg_scan_display #(.SCAN_DIV(8), .GAP_CYCLES(2)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .DataIn    (DataIn),
    .DpIn      (DpIn),
    .BlankIn   (BlankIn),
    .Load      (Load),
    .AN        (AN),
    .SEG       (SEG),
    .FrameTick (FrameTick)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [7:0] seg;
    logic       ft;
  } exp_t;

  exp_t q[$];
  exp_t monE;
  int compared = 0;
  int failed   = 0;

  // Entry cyc = n means: pins as seen after the n-th rising edge.
  always @(negedge CLK) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      monE = q.pop_front();
      compared++;
      if (monE.cyc != cyc) begin
        failed++;
        $display("FAIL stale cyc=%0d: entry for cyc %0d not checked in time", cyc, monE.cyc);
      end else if (AN !== monE.an || SEG !== monE.seg || FrameTick !== monE.ft) begin
        failed++;
        $display("FAIL pins cyc=%0d: got AN=%h SEG=%h FT=%b, want AN=%h SEG=%h FT=%b",
                 cyc, AN, SEG, FrameTick, monE.an, monE.seg, monE.ft);
      end
    end
  end

  task automatic pushPins(input int c, input logic [3:0] an, input logic [7:0] seg, input logic ft);
    exp_t e;
    e.cyc = c; e.an = an; e.seg = seg; e.ft = ft;
    q.push_back(e);
  endtask

  // segs = {seg3,seg2,seg1,seg0} hand-decoded; base = edge that starts the frame.
  task automatic expectFrame(input int base, input logic [31:0] segs,
                             input logic [3:0] blank, input int n);
    for (int j = 1; j <= n; j++) begin
      int slot;
      int c;
      slot = (j - 1) / 8;
      c    = (j - 1) % 8;
      if (c < 2 || blank[slot])
        pushPins(base + j, 4'hF, 8'hFF, j == 32);
      else
        pushPins(base + j, ~(4'b0001 << slot), segs[slot*8 +: 8], j == 32);
    end
  endtask

  task automatic toEdge(input int e);
    while (cyc < e) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Load is high in the cycle sampled by edge e.
  task automatic doLoad(input int e, input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
    toEdge(e - 1);
    DataIn = d; DpIn = dp; BlankIn = bl; Load = 1'b1;
    toEdge(e);
    Load = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int r2;
    Reset = 1'b0; Load = 1'b0; DataIn = 16'h0; DpIn = 4'h0; BlankIn = 4'h0;
    r = 4;

    for (int c = 1; c <= r; c++) pushPins(c, 4'hF, 8'hFF, 1'b0);
    expectFrame(r, 32'hFFFFFFFF, 4'hF, 32);
    toEdge(r);
    Reset = 1'b1;

    // 1234 shown from frame 1
    expectFrame(r + 32, 32'hF9A4B099, 4'h0, 32);
    doLoad(r + 5, 16'h1234, 4'h0, 4'h0);

    // ABCD loaded mid-frame 1 appears only in frame 2
    expectFrame(r + 64, 32'h8883C6A1, 4'h0, 32);
    doLoad(r + 44, 16'hABCD, 4'h0, 4'h0);

    // Load on the boundary edge bypasses pending: 0F0F, dp on digit0
    expectFrame(r + 96, 32'hC08EC00E, 4'h0, 32);
    doLoad(r + 96, 16'h0F0F, 4'b0001, 4'h0);

    // Two loads in frame 3; last wins, digit2 blanked
    expectFrame(r + 128, 32'hA4FFA4A4, 4'b0100, 32);
    doLoad(r + 99, 16'h1111, 4'h0, 4'h0);
    doLoad(r + 116, 16'h2222, 4'h0, 4'b0100);

    // Frame 5 runs until reset lands at cnt=5, idx=2
    expectFrame(r + 160, 32'hA4FFA4A4, 4'b0100, 21);
    for (int c = r + 182; c <= r + 184; c++) pushPins(c, 4'hF, 8'hFF, 1'b0);
    toEdge(r + 181);
    Reset = 1'b0;
    toEdge(r + 184);
    Reset = 1'b1;

    // Dark after reset with no Load; FrameTick 32 cycles after release, then every 32
    r2 = r + 184;
    expectFrame(r2, 32'hFFFFFFFF, 4'hF, 32);
    expectFrame(r2 + 32, 32'hFFFFFFFF, 4'hF, 32);
    toEdge(r2 + 66);

    if (q.size() != 0) begin
      $display("FAIL drain: %0d expected entries never checked, want 0", q.size());
      failed += q.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
